// File: rtl/backoff_timer_if.sv
// Control/status bundle between the MAC transmit logic and the backoff timer.
interface backoff_timer_if #(
  parameter int unsigned LFSR_WIDTH    = 16,
  parameter int unsigned BACKOFF_LIMIT = 10,
  parameter int unsigned ATTEMPT_LIMIT = 16
);
  logic                             seed_load;
  logic [LFSR_WIDTH-1:0]            seed;
  logic                             start;
  logic                             clear;
  logic                             pause;
  logic                             ready;
  logic                             expire;
  logic                             abort;
  logic [$clog2(ATTEMPT_LIMIT)-1:0] attempt;
  logic [BACKOFF_LIMIT-1:0]         slots_left;

  modport master (
    output seed_load, seed, start, clear, pause,
    input  ready, expire, abort, attempt, slots_left
  );

  modport slave (
    input  seed_load, seed, start, clear, pause,
    output ready, expire, abort, attempt, slots_left
  );
endinterface

// File: rtl/backoff_timer.sv
// Truncated binary exponential backoff timer with a free-running XNOR LFSR.
module backoff_timer #(
  parameter int unsigned           LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = 16'hB400,
  parameter int unsigned           BACKOFF_LIMIT = 10,
  parameter int unsigned           ATTEMPT_LIMIT = 16,
  parameter int unsigned           SLOT_CYCLES   = 256
) (
  input logic            clk_i,
  input logic            rst_ni,
  backoff_timer_if.slave bus
);
  localparam int unsigned AW = $clog2(ATTEMPT_LIMIT);
  localparam int unsigned TW = $clog2(SLOT_CYCLES);
  localparam logic [AW:0]   ALIM     = ATTEMPT_LIMIT[AW:0];
  localparam logic [TW-1:0] TIMER_MAX = TW'(SLOT_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [LFSR_WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [AW-1:0]            attempt_q, attempt_d;
  logic [BACKOFF_LIMIT-1:0] slots_q, slots_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic                     expire_q, expire_d;
  logic                     abort_q, abort_d;

  logic [AW:0]              n_attempt;
  int unsigned              k_exp;
  logic [BACKOFF_LIMIT-1:0] draw;

  // Next attempt number and the truncated random slot draw from the current LFSR.
  always_comb begin
    n_attempt = {1'b0, attempt_q} + (AW+1)'(1);
    k_exp     = (32'(n_attempt) < BACKOFF_LIMIT) ? 32'(n_attempt) : BACKOFF_LIMIT;
    draw      = '0;
    for (int unsigned i = 0; i < BACKOFF_LIMIT; i++) begin
      draw[i] = (i < k_exp) ? lfsr_q[i] : 1'b0;
    end
  end

  // LFSR free-runs; an all-ones seed is replaced by zero to avoid XNOR lock-up.
  always_comb begin
    if (bus.seed_load) begin
      lfsr_d = (&bus.seed) ? '0 : bus.seed;
    end else begin
      lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ~^(lfsr_q & LFSR_TAPS)};
    end
  end

  // Backoff control: clear beats start, start beats slot timing.
  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    slots_d   = slots_q;
    timer_d   = timer_q;
    expire_d  = 1'b0;
    abort_d   = 1'b0;
    if (bus.clear) begin
      attempt_d = '0;
      slots_d   = '0;
      timer_d   = '0;
      state_d   = IDLE;
    end else if (bus.start) begin
      if (n_attempt == ALIM) begin
        abort_d   = 1'b1;
        attempt_d = '0;
        slots_d   = '0;
        timer_d   = '0;
        state_d   = IDLE;
      end else begin
        attempt_d = n_attempt[AW-1:0];
        slots_d   = draw;
        timer_d   = '0;
        state_d   = WAIT;
      end
    end else if (state_q == WAIT && !bus.pause) begin
      if (slots_q == '0) begin
        expire_d = 1'b1;
        state_d  = IDLE;
      end else if (timer_q == TIMER_MAX) begin
        timer_d = '0;
        slots_d = slots_q - BACKOFF_LIMIT'(1);
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // State, counters, LFSR and output pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lfsr_q    <= '0;
      attempt_q <= '0;
      slots_q   <= '0;
      timer_q   <= '0;
      expire_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      attempt_q <= attempt_d;
      slots_q   <= slots_d;
      timer_q   <= timer_d;
      expire_q  <= expire_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.expire     = expire_q;
  assign bus.abort      = abort_q;
  assign bus.attempt    = attempt_q;
  assign bus.slots_left = slots_q;
endmodule

// File: tb/tb_backoff_timer.sv
// Directed bench for backoff_timer with hand-computed expectations.
module tb_backoff_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;

  backoff_timer_if #(
    .LFSR_WIDTH(16), .BACKOFF_LIMIT(10), .ATTEMPT_LIMIT(16)
  ) bif ();

  backoff_timer #(
    .LFSR_WIDTH(16), .LFSR_TAPS(16'hB400), .BACKOFF_LIMIT(10),
    .ATTEMPT_LIMIT(16), .SLOT_CYCLES(256)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge until expire is seen; pause held for
  // pause_len edges beginning after edge pause_at (pause_at < 0 = no pause).
  task automatic wait_expire(input int pause_at, input int pause_len, output int cnt);
    cnt = 0;
    while (bif.expire !== 1'b1 && cnt < 3000) begin
      if (cnt == pause_at) bif.pause = 1'b1;
      if (cnt == pause_at + pause_len) bif.pause = 1'b0;
      tick();
      cnt++;
    end
    bif.pause = 1'b0;
  endtask

  task automatic do_clear();
    bif.clear = 1'b1;
    tick();
    bif.clear = 1'b0;
  endtask

  task automatic load_seed(input logic [15:0] s);
    bif.seed_load = 1'b1;
    bif.seed      = s;
    tick();
    bif.seed_load = 1'b0;
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  initial begin
    bif.seed_load = 1'b0;
    bif.seed      = '0;
    bif.start     = 1'b0;
    bif.clear     = 1'b0;
    bif.pause     = 1'b0;

    // Reset state
    #23;
    chk("rst_ready", 32'(bif.ready), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("rst_attempt", 32'(bif.attempt), 32'd0);
    chk("rst_slots", 32'(bif.slots_left), 32'd0);
    chk("rst_expire", 32'(bif.expire), 32'd0);
    chk("rst_abort", 32'(bif.abort), 32'd0);

    // All-ones seed loads 0; sequence 0 -> 1 -> 3 -> 7 ...
    load_seed(16'hFFFF);
    pulse_start();                       // draws lfsr[0] of 0
    chk("ff_attempt", 32'(bif.attempt), 32'd1);
    chk("ff_slots0", 32'(bif.slots_left), 32'd0);
    chk("ff_ready0", 32'(bif.ready), 32'd0);
    tick();
    chk("ff_expire", 32'(bif.expire), 32'd1);
    chk("ff_ready1", 32'(bif.ready), 32'd1);
    pulse_start();                       // lfsr now 3, k=2
    chk("ff_slots3", 32'(bif.slots_left), 32'd3);
    chk("ff_attempt2", 32'(bif.attempt), 32'd2);
    chk("ff_expire_1cyc", 32'(bif.expire), 32'd0);
    do_clear();
    chk("clr_attempt", 32'(bif.attempt), 32'd0);
    chk("clr_ready", 32'(bif.ready), 32'd1);
    chk("clr_slots", 32'(bif.slots_left), 32'd0);

    // Single slot: expire 257 edges after start
    load_seed(16'h0003);
    pulse_start();
    chk("ss_attempt", 32'(bif.attempt), 32'd1);
    chk("ss_slots", 32'(bif.slots_left), 32'd1);
    chk("ss_ready", 32'(bif.ready), 32'd0);
    wait_expire(-10, 0, n);
    chk("ss_latency", 32'(n), 32'd257);
    chk("ss_ready_exp", 32'(bif.ready), 32'd1);
    tick();
    chk("ss_expire_end", 32'(bif.expire), 32'd0);
    chk("ss_attempt_kept", 32'(bif.attempt), 32'd1);

    // Pause for 100 cycles mid-slot
    do_clear();
    load_seed(16'h0003);
    pulse_start();
    wait_expire(50, 100, n);
    chk("pz_latency", 32'(n), 32'd357);
    tick();
    chk("pz_expire_end", 32'(bif.expire), 32'd0);

    // Zero draw
    do_clear();
    load_seed(16'h0000);
    pulse_start();
    chk("zd_slots", 32'(bif.slots_left), 32'd0);
    chk("zd_ready", 32'(bif.ready), 32'd0);
    wait_expire(-10, 0, n);
    chk("zd_latency", 32'(n), 32'd1);

    // Exponent truncation then attempt limit
    do_clear();
    for (int i = 0; i < 11; i++) pulse_start();
    chk("tr_attempt11", 32'(bif.attempt), 32'd11);
    load_seed(16'hFFF0);
    pulse_start();
    chk("tr_attempt12", 32'(bif.attempt), 32'd12);
    chk("tr_slots", 32'(bif.slots_left), 32'h3F0);
    for (int i = 0; i < 3; i++) pulse_start();
    chk("al_attempt15", 32'(bif.attempt), 32'd15);
    chk("al_ready_wait", 32'(bif.ready), 32'd0);
    pulse_start();
    chk("al_abort", 32'(bif.abort), 32'd1);
    chk("al_attempt0", 32'(bif.attempt), 32'd0);
    chk("al_ready", 32'(bif.ready), 32'd1);
    chk("al_slots", 32'(bif.slots_left), 32'd0);
    chk("al_no_expire", 32'(bif.expire), 32'd0);
    tick();
    chk("al_abort_1cyc", 32'(bif.abort), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("al_idle_expire", 32'(bif.expire), 32'd0);
    end

    // clear and start together in WAIT
    load_seed(16'h0003);
    pulse_start();
    chk("pr_wait", 32'(bif.ready), 32'd0);
    bif.clear = 1'b1;
    bif.start = 1'b1;
    tick();
    bif.clear = 1'b0;
    bif.start = 1'b0;
    chk("pr_attempt", 32'(bif.attempt), 32'd0);
    chk("pr_ready", 32'(bif.ready), 32'd1);
    chk("pr_expire", 32'(bif.expire), 32'd0);
    chk("pr_abort", 32'(bif.abort), 32'd0);
    tick();
    chk("pr_expire2", 32'(bif.expire), 32'd0);

    // Reset mid-WAIT with 500 slots
    for (int i = 0; i < 8; i++) pulse_start();
    load_seed(16'h01F4);
    pulse_start();
    chk("rw_attempt9", 32'(bif.attempt), 32'd9);
    chk("rw_slots500", 32'(bif.slots_left), 32'd500);
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_ready", 32'(bif.ready), 32'd1);
    chk("rw_attempt", 32'(bif.attempt), 32'd0);
    chk("rw_slots", 32'(bif.slots_left), 32'd0);
    chk("rw_expire", 32'(bif.expire), 32'd0);
    chk("rw_abort", 32'(bif.abort), 32'd0);
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_post_expire", 32'(bif.expire), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/backoff_timer.md
# backoff_timer

Parametrised truncated binary exponential backoff timer for the MAC transmit path. It counts collisions since the last successful transmission and draws a random slot count r in [0, 2^k) from a free-running LFSR, with k = min(attempt, BACKOFF_LIMIT). It times r slots of SLOT_CYCLES clocks, honouring a deferral pause, then pulses `expire`. It pulses `abort` instead when the attempt limit is hit.

## Interface
- LFSR_WIDTH, 16: LFSR length; must be ≥ BACKOFF_LIMIT.
- LFSR_TAPS, 16'hB400: feedback tap mask (bit i set = lfsr[i] tapped).
- BACKOFF_LIMIT, 10: maximum backoff exponent k.
- ATTEMPT_LIMIT, 16: collision count that forces abort; must be ≥ 2.
- SLOT_CYCLES, 256: clocks per slot; must be ≥ 2.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- seed_load  in  1  load `seed` into the LFSR this edge.
- seed  in  LFSR_WIDTH  LFSR seed value.
- start  in  1  collision occurred; begin a new backoff.
- clear  in  1  transmission succeeded; zero the attempt count and cancel any backoff.
- pause  in  1  carrier present; freezes backoff timing.
- ready  out  1  high when no backoff is in progress (IDLE).
- expire  out  1  one-cycle pulse: backoff complete, retransmit allowed.
- abort  out  1  one-cycle pulse: attempt limit reached, frame dropped.
- attempt  out  $clog2(ATTEMPT_LIMIT)  collisions since the last clear.
- slots_left  out  BACKOFF_LIMIT  remaining slots in the current backoff.

## Operation
- LFSR:
  - Fibonacci, XNOR feedback; shifts left every cycle, including during pause and IDLE.
  - Update: lfsr <= {lfsr[LFSR_WIDTH-2:0], ~^(lfsr & LFSR_TAPS)}.
  - All-zeros is legal. The all-ones lock-up state is never entered: a seed of all ones loads 0 instead.
  - `seed_load` overrides the shift for that edge.
- FSM states: IDLE and WAIT.
- Priority: `clear` > `start`. `seed_load` acts independently on the LFSR only.
- clear, in any state: attempt <= 0, slots_left <= 0, slot timer <= 0, go to IDLE. No pulse is generated.
- start, in IDLE or WAIT; a start in WAIT restarts the backoff. Let n = attempt+1:
  - If n == ATTEMPT_LIMIT: pulse `abort`, set attempt <= 0 and slots_left <= 0, go to IDLE.
  - Otherwise: attempt <= n, k = min(n, BACKOFF_LIMIT), slots_left <= zero-extended lfsr[k-1:0], slot timer <= 0, go to WAIT.
  - The LFSR value used is the one present before the edge; a `seed_load` on the same edge does not affect the draw.
- WAIT, no start, no clear:
  - pause=1: timer, slots_left and expiry are all frozen.
  - slots_left == 0: pulse `expire`, go to IDLE. attempt is retained.
  - Otherwise the timer increments. When the timer == SLOT_CYCLES-1 it wraps to 0 and slots_left decrements.
- Width rules:
  - Slot timer is $clog2(SLOT_CYCLES) bits.
  - attempt never exceeds ATTEMPT_LIMIT-1.
  - slots_left never wraps below 0.

## Timing
- Reset values: ready=1, expire=0, abort=0, attempt=0, slots_left=0, LFSR=0, slot timer=0, state IDLE.
- ready = (state == IDLE), derived directly from the state register.
- expire and abort are registered pulses, exactly one cycle wide.
- Expire latency, start sampled at edge E0, draw r, no pause: expire is high in the cycle after edge E(r·SLOT_CYCLES+1). Every paused WAIT cycle adds one cycle.
- r = 0: expire follows one cycle after start.
- abort is high in the cycle after the start edge. ready stays 1 throughout.
- Reset asserted mid-WAIT: immediate return to reset values. No expire is produced.
- start and expire-condition on the same edge: start wins and no expire pulses.
- clear and start on the same edge: clear wins and attempt becomes 0.

## Test plan
- Reset and seed load:
  - Release reset → ready=1, attempt=0, slots_left=0.
  - seed_load with seed=16'hFFFF → LFSR reads 0 after the edge, then 0 shifts into a known model sequence.
- Single slot:
  - Load seed 16'h0003, start on the next cycle → attempt=1, slots_left=1, ready=0.
  - Expire pulses 257 cycles after the start edge, then ready=1.
- Exponent truncation:
  - Drive attempt to 11 via starts, load seed 16'hFFF0, then start → attempt=12, slots_left=10'h3F0 (1008, k capped at 10).
- Pause and zero draw:
  - Seed 16'h0003, start, hold pause for 100 cycles mid-slot → expire at cycle 357.
  - After clear, seed 16'h0000 then start → expire one cycle after start.
- Attempt limit: 16 starts with no clear → the 16th produces a one-cycle abort, attempt=0, ready=1, and no expire.
- Priority and reset:
  - clear and start together in WAIT → IDLE, attempt=0, no pulse.
  - Reset driven low mid-WAIT with slots_left=500 → outputs return to reset values immediately.
